uart_tx_fifo: RTL and testbench

Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from a host over a valid/ready interface and stores them in a circular FIFO. It then drains them one at a time into the transmitter using the transmitter's UART_Start / UART_Ready / UART_Busy handshake, so the host can burst data without tracking line timing.

---
 rtl/uart_tx_fifo.sv | 74 +++++++
 tb/tb_uart_tx_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that drains into a UART transmitter via a Start/Ready/Busy handshake
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_data/s_ready host push interface (valid/ready)
//   flush                 synchronous clear of stored bytes and overflow
//   UART_Start, tx_data   start request and byte presented to the transmitter
//   UART_Ready, UART_Busy transmitter status
//   level                 number of stored bytes (0..DEPTH)
//   overflow              sticky: host offered a byte while full
//   tx_active             a launched frame is still in progress
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int DATA_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              flush,
  output logic              UART_Start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              UART_Ready,
  input  logic              UART_Busy,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              tx_active
);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT_DONE = 2'd2;
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_level;
  logic [1:0] r_state;
  logic r_start, r_overflow;
  logic [DATA_W-1:0] r_tx_data;
  logic w_push, w_pop, w_launch;
  assign s_ready = r_level != FULL;
  assign w_push = s_valid && s_ready && !flush;
  // The byte leaves the FIFO once the transmitter has visibly taken it.
  assign w_pop = r_state == LAUNCH && UART_Busy && !flush;
  // A flush empties the FIFO this cycle, so nothing may be launched alongside it.
  assign w_launch = r_state == IDLE && r_level != '0 && UART_Ready && !flush;
  assign UART_Start = r_start;
  assign tx_data = r_tx_data;
  assign level = r_level;
  assign overflow = r_overflow;
  assign tx_active = r_state != IDLE;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level <= '0;
      r_state <= IDLE;
      r_start <= 1'b0;
      r_tx_data <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= flush ? '0 : r_wr_ptr + {{(AW-1){1'b0}}, w_push};
      r_rd_ptr <= flush ? '0 : r_rd_ptr + {{(AW-1){1'b0}}, w_pop};
      r_level <= flush ? '0 : r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      r_overflow <= !flush && (r_overflow || (s_valid && !s_ready));
      if (w_launch) r_tx_data <= r_mem[r_rd_ptr];
      r_start <= w_launch || (r_start && !UART_Busy && !flush);
      // A flush in LAUNCH abandons the byte unless the transmitter already took it.
      r_state <= w_launch ? LAUNCH :
                 r_state == LAUNCH ? (UART_Busy ? WAIT_DONE : flush ? IDLE : LAUNCH) :
                 r_state == WAIT_DONE && (UART_Busy || !UART_Ready) ? WAIT_DONE : IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed + randomized bench with a queue-based FIFO model and a simple transmitter model
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n, s_valid, s_ready, flush, UART_Start, UART_Ready, UART_Busy, overflow, tx_active;
  logic [7:0] s_data, tx_data;
  logic [4:0] level;
  logic [7:0] q_ref [$];
  logic ovf;
  int busy_cnt, frame_len, n_frames, checks, errors, starts, f0;
  bit tx_hold, tx_mute, seen_idle, prev_start;
  always #5 clk = ~clk;
  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush(flush), .UART_Start(UART_Start), .tx_data(tx_data), .UART_Ready(UART_Ready),
    .UART_Busy(UART_Busy), .level(level), .overflow(overflow), .tx_active(tx_active)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One clock cycle: transmitter model and reference model act on the falling edge,
  // then the DUT state after the rising edge is compared against the model.
  task automatic tick();
    bit pop, push;
    @(negedge clk);
    if (busy_cnt > 0) busy_cnt--;
    else if (UART_Start && !tx_mute) busy_cnt = frame_len;
    UART_Busy = busy_cnt > 0;
    UART_Ready = !UART_Busy && !tx_hold;
    if (!tx_active) seen_idle = 1;
    if (UART_Start && !prev_start) begin
      check("idle_gap", {31'd0, seen_idle}, 1);
      seen_idle = 0;
    end
    prev_start = UART_Start;
    if (UART_Start) check("start_nonempty", {31'd0, q_ref.size() != 0}, 1);
    pop = UART_Start && UART_Busy && !flush;
    push = s_valid && !flush && q_ref.size() != DEPTH;
    ovf = !flush && (ovf || (s_valid && q_ref.size() == DEPTH));
    if (flush) q_ref.delete();
    if (pop) begin
      check("tx_order", {24'd0, tx_data}, {24'd0, q_ref[0]});
      void'(q_ref.pop_front());
      n_frames++;
    end
    if (push) q_ref.push_back(s_data);
    @(posedge clk);
    #1;
    check("level", {27'd0, level}, q_ref.size());
    check("s_ready", {31'd0, s_ready}, {31'd0, q_ref.size() != DEPTH});
    check("overflow", {31'd0, overflow}, {31'd0, ovf});
    if (UART_Start) starts++;
  endtask
  initial begin
    rst_n = 0; s_valid = 0; s_data = 0; flush = 0; UART_Busy = 0; UART_Ready = 1;
    tx_hold = 0; tx_mute = 0; frame_len = 100; busy_cnt = 0; n_frames = 0;
    checks = 0; errors = 0; starts = 0; ovf = 0; seen_idle = 1; prev_start = 0;
    #12;
    check("rst_level", {27'd0, level}, 0);
    check("rst_ready", {31'd0, s_ready}, 1);
    check("rst_start", {31'd0, UART_Start}, 0);
    check("rst_txdata", {24'd0, tx_data}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    check("rst_active", {31'd0, tx_active}, 0);
    @(posedge clk); #1; rst_n = 1;
    // single byte, long frame, two-cycle launch latency
    s_valid = 1; s_data = 8'h55; tick(); s_valid = 0;
    check("lat_cycle1", {31'd0, UART_Start}, 0);
    tick();
    check("lat_cycle2", {31'd0, UART_Start}, 1);
    check("lat_txdata", {24'd0, tx_data}, 8'h55);
    for (int i = 0; i < 300 && (tx_active || UART_Busy); i++) tick();
    check("single_done", {31'd0, tx_active || UART_Busy}, 0);
    check("single_frames", n_frames, 1);
    // fill to full with the transmitter held off, then one refused push
    frame_len = 3; tx_hold = 1;
    for (int i = 1; i <= 16; i++) begin s_valid = 1; s_data = 8'(i); tick(); end
    s_data = 8'h11; tick(); s_valid = 0;
    check("full_level", {27'd0, level}, 16);
    check("full_ready", {31'd0, s_ready}, 0);
    check("full_ovf", {31'd0, overflow}, 1);
    tx_hold = 0; f0 = n_frames;
    for (int i = 0; i < 400 && (q_ref.size() != 0 || tx_active); i++) tick();
    check("drain_frames", n_frames - f0, 16);
    check("drain_level", {27'd0, level}, 0);
    check("ovf_sticky", {31'd0, overflow}, 1);
    // simultaneous push and pop at level 5, pointers already wrapped once
    tx_hold = 1;
    for (int i = 0; i < 5; i++) begin s_valid = 1; s_data = 8'($urandom); tick(); end
    s_valid = 0; tx_hold = 0;
    for (int i = 0; i < 20 && !UART_Start; i++) tick();
    check("pp_launch", {31'd0, UART_Start}, 1);
    s_valid = 1; s_data = 8'($urandom); tick(); s_valid = 0;
    check("pp_level", {27'd0, level}, 5);
    // randomized traffic with occasional stalls and flushes
    for (int i = 0; i < 1500; i++) begin
      s_valid = $urandom_range(0, 2) != 0;
      s_data = 8'($urandom);
      frame_len = $urandom_range(1, 6);
      tx_hold = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 99) == 0;
      tick();
    end
    s_valid = 0; flush = 0; tx_hold = 0;
    for (int i = 0; i < 1000 && (q_ref.size() != 0 || tx_active); i++) tick();
    check("rand_drained", {31'd0, q_ref.size() == 0 && !tx_active}, 1);
    // flush while stuck in LAUNCH with Busy low
    tx_hold = 1;
    for (int i = 0; i < 17; i++) begin s_valid = 1; s_data = 8'($urandom); tick(); end
    s_valid = 0; tx_hold = 0; tx_mute = 1;
    for (int i = 0; i < 20 && !UART_Start; i++) tick();
    tick();
    check("stall_start", {31'd0, UART_Start}, 1);
    check("stall_ovf", {31'd0, overflow}, 1);
    f0 = n_frames; flush = 1; tick(); flush = 0;
    check("flush_start", {31'd0, UART_Start}, 0);
    check("flush_active", {31'd0, tx_active}, 0);
    check("flush_level", {27'd0, level}, 0);
    check("flush_ovf", {31'd0, overflow}, 0);
    starts = 0;
    for (int i = 0; i < 20; i++) tick();
    check("flush_no_start", starts, 0);
    check("flush_no_frame", n_frames - f0, 0);
    tx_mute = 0;
    // asynchronous reset in WAIT_DONE with three bytes stored
    frame_len = 50;
    for (int i = 0; i < 4; i++) begin s_valid = 1; s_data = 8'($urandom); tick(); end
    s_valid = 0;
    check("wd_active", {31'd0, tx_active}, 1);
    check("wd_start", {31'd0, UART_Start}, 0);
    check("wd_level", {27'd0, level}, 3);
    #2 rst_n = 0;
    #1;
    q_ref.delete(); ovf = 0;
    check("arst_level", {27'd0, level}, 0);
    check("arst_ready", {31'd0, s_ready}, 1);
    check("arst_start", {31'd0, UART_Start}, 0);
    check("arst_txdata", {24'd0, tx_data}, 0);
    check("arst_ovf", {31'd0, overflow}, 0);
    check("arst_active", {31'd0, tx_active}, 0);
    tick(); rst_n = 1; starts = 0;
    for (int i = 0; i < 60; i++) tick();
    check("arst_no_start", starts, 0);
    f0 = n_frames; frame_len = 4;
    s_valid = 1; s_data = 8'hA5; tick(); s_valid = 0;
    for (int i = 0; i < 50 && (q_ref.size() != 0 || tx_active); i++) tick();
    check("arst_restart", n_frames - f0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
